// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the sequential signed divider.
// The master issues operands and the slave returns the quotient, remainder and flags.
interface seq_divider_if #(
    parameter int DW = 16
);
    logic                   start;
    logic signed [2*DW-1:0] dividend;
    logic signed [DW-1:0]   divisor;
    logic signed [DW-1:0]   quotient;
    logic signed [DW-1:0]   remainder;
    logic                   busy;
    logic                   done;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential signed 2*DW / DW divider: magnitude restoring shift/subtract, one quotient bit
// per clock, followed by a sign-fix step. The result is truncated toward zero.
module seq_divider #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(DW) + 1;
    localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic signed [2*DW-1:0] r_dividend;
    logic signed [DW-1:0]   r_divisor;
    logic [2*DW-1:0]        r_abs_a;
    logic [DW-1:0]          r_abs_b;
    logic                   r_sign_q;
    logic                   r_sign_r;
    logic [CW-1:0]          r_cnt;
    logic [DW:0]            r_rem;
    logic [DW-1:0]          r_quo;
    logic signed [DW-1:0]   r_q_out;
    logic signed [DW-1:0]   r_r_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_dbz;
    logic                   r_ovf;

    logic                   w_chk_dbz;
    logic                   w_chk_ovf;
    logic [DW:0]            w_shift;
    logic [DW:0]            w_diff;
    logic                   w_ge;
    logic                   w_fix_ovf;
    logic [DW-1:0]          w_q_fix;
    logic [DW-1:0]          w_r_fix;

    // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
    function automatic logic [2*DW-1:0] cneg_wide(input logic [2*DW-1:0] x, input logic neg);
        return neg ? (~x + (2*DW)'(1)) : x;
    endfunction

    function automatic logic [DW-1:0] cneg(input logic [DW-1:0] x, input logic neg);
        return neg ? (~x + DW'(1)) : x;
    endfunction

    assign w_chk_dbz = (r_divisor == '0);
    assign w_chk_ovf = (r_abs_a[2*DW-1:DW] >= r_abs_b);

    // A bit shifted out of R means the shifted value already exceeds any DW-bit divisor.
    assign w_shift = {r_rem[DW-1:0], r_quo[DW-1]};
    assign w_diff  = w_shift - {1'b0, r_abs_b};
    assign w_ge    = r_rem[DW] | (w_shift >= {1'b0, r_abs_b});

    assign w_fix_ovf = r_sign_q ? (r_quo > HALF) : r_quo[DW-1];
    assign w_q_fix   = cneg(r_quo, r_sign_q);
    assign w_r_fix   = cneg(r_rem[DW-1:0], r_sign_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LOAD;
            S_LOAD:  w_next = S_CHECK;
            S_CHECK: w_next = (w_chk_dbz || w_chk_ovf) ? S_DONE : S_ITER;
            S_ITER:  if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_abs_a    <= '0;
            r_abs_b    <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_q_out    <= '0;
            r_r_out    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dividend <= bus.dividend;
                        r_divisor  <= bus.divisor;
                    end
                end
                S_LOAD: begin
                    r_abs_a  <= cneg_wide(r_dividend, r_dividend[2*DW-1]);
                    r_abs_b  <= cneg(r_divisor, r_divisor[DW-1]);
                    r_sign_q <= r_dividend[2*DW-1] ^ r_divisor[DW-1];
                    r_sign_r <= r_dividend[2*DW-1];
                    r_cnt    <= CW'(DW);
                    r_q_out  <= '0;
                    r_r_out  <= '0;
                    r_dbz    <= 1'b0;
                    r_ovf    <= 1'b0;
                end
                S_CHECK: begin
                    if (w_chk_dbz) begin
                        r_dbz <= 1'b1;
                    end else if (w_chk_ovf) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_rem <= {1'b0, r_abs_a[2*DW-1:DW]};
                        r_quo <= r_abs_a[DW-1:0];
                    end
                end
                S_ITER: begin
                    r_rem <= w_ge ? w_diff : w_shift;
                    r_quo <= {r_quo[DW-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    if (w_fix_ovf) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_q_out <= w_q_fix;
                        r_r_out <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = r_q_out;
    assign bus.remainder   = r_r_out;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: an arithmetic reference model with a per-cycle compare process,
// literal-pinned directed operations, then randomized start/operand traffic.
module tb_seq_divider;
    logic clk;
    logic rst;

    seq_divider_if #(.DW(16)) bus ();

    seq_divider #(.DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain signed arithmetic, truncation toward zero, range checks on the result.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov, output int len);
        longint sa, sb, ma, mb, qq, rr;
        bit neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = '0; r = '0; dz = 1'b0; ov = 1'b0; len = 20;
        if (sb == 0) begin
            dz = 1'b1;
            len = 3;
        end else begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            if (ma >= mb * 65536) begin
                ov = 1'b1;
                len = 3;
            end else begin
                qq = ma / mb;
                rr = ma % mb;
                neg = (sa < 0) != (sb < 0);
                if (qq > (neg ? 64'sd32768 : 64'sd32767)) begin
                    ov = 1'b1;
                end else begin
                    q = 16'(neg ? -qq : qq);
                    r = 16'((sa < 0) ? -rr : rr);
                end
            end
        end
    endfunction

    logic        m_live = 1'b0;
    logic        m_act = 1'b0;
    int          m_k = 0;
    int          m_len = 20;
    logic [15:0] m_q = '0, m_r = '0;
    logic        m_dz = 1'b0, m_ov = 1'b0;
    logic [15:0] p_q, p_r;
    logic        p_dz, p_ov;

    // Model timeline: k counts edges since acceptance; outputs clear at k=1, results at k=len-1.
    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0; m_k = 0;
            m_q = '0; m_r = '0; m_dz = 1'b0; m_ov = 1'b0;
        end else if (m_act) begin
            m_k++;
            if (m_k == m_len) begin
                m_act = 1'b0;
            end else begin
                if (m_k == 1) begin
                    m_q = '0; m_r = '0; m_dz = 1'b0; m_ov = 1'b0;
                end
                if (m_k == m_len - 1) begin
                    m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
                end
            end
        end else if (bus.start) begin
            model(bus.dividend, bus.divisor, p_q, p_r, p_dz, p_ov, m_len);
            m_act = 1'b1;
            m_k = 0;
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk16("busy", 16'(bus.busy), 16'(m_act));
            chk16("done", 16'(bus.done), 16'(m_act && (m_k == m_len - 1)));
            chk16("quotient", bus.quotient, m_q);
            chk16("remainder", bus.remainder, m_r);
            chk16("div_by_zero", 16'(bus.div_by_zero), 16'(m_dz));
            chk16("overflow", 16'(bus.overflow), 16'(m_ov));
        end
    end

    // Issues one operation; scrambles the operands while busy and optionally re-pulses start at cycle inj.
    task automatic run_op(input string name, input logic [31:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edz, input logic eov, input int elat, input int inj);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            bus.start = (n == inj);
            bus.dividend = $urandom;
            bus.divisor = 16'($urandom);
            if (bus.done || n >= 40) break;
        end
        chk_int({name, "_latency"}, n, elat);
        chk16({name, "_q"}, bus.quotient, eq);
        chk16({name, "_r"}, bus.remainder, er);
        chk16({name, "_dz"}, 16'(bus.div_by_zero), 16'(edz));
        chk16({name, "_ov"}, 16'(bus.overflow), 16'(eov));
    endtask

    task automatic run_abort();
        logic saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd7;
        repeat (10) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk16("abort_busy", 16'(bus.busy), 16'd0);
        chk16("abort_done", 16'(bus.done), 16'd0);
        chk16("abort_q", bus.quotient, 16'd0);
        chk16("abort_r", bus.remainder, 16'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk16("abort_no_done", 16'(saw_done), 16'd0);
    endtask

    task automatic gen_operands();
        int mode;
        longint sd, mb, qv, rr, prod;
        mode = int'($urandom_range(0, 9));
        if (mode == 0) begin
            bus.dividend = $urandom;
            bus.divisor = '0;
        end else if (mode == 1) begin
            bus.dividend = $urandom;
            bus.divisor = 16'($urandom);
        end else if (mode == 2) begin
            case ($urandom_range(0, 3))
                0: bus.dividend = 32'h8000_0000;
                1: bus.dividend = 32'h7FFF_FFFF;
                2: bus.dividend = 32'hC000_0000;
                default: bus.dividend = 32'h4000_0000;
            endcase
            case ($urandom_range(0, 3))
                0: bus.divisor = 16'h8000;
                1: bus.divisor = 16'h7FFF;
                2: bus.divisor = 16'h0001;
                default: bus.divisor = 16'hFFFF;
            endcase
        end else begin
            sd = longint'($signed(16'($urandom)));
            if (sd == 0) sd = 1;
            mb = (sd < 0) ? -sd : sd;
            qv = longint'($signed(16'($urandom)));
            rr = longint'($urandom_range(0, 32'(mb - 1)));
            prod = qv * sd;
            bus.dividend = 32'((prod < 0) ? prod - rr : prod + rr);
            bus.divisor = 16'(sd);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk16("reset_busy", 16'(bus.busy), 16'd0);
        chk16("reset_done", 16'(bus.done), 16'd0);
        chk16("reset_q", bus.quotient, 16'd0);
        chk16("reset_flags", {14'd0, bus.div_by_zero, bus.overflow}, 16'd0);
        rst = 1'b0;

        run_op("pos_pos", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 20, 0);
        run_op("neg_pos", -32'sd100, 16'd7, -16'sd14, -16'sd2, 1'b0, 1'b0, 20, 0);
        run_op("pos_neg", 32'd100, -16'sd7, -16'sd14, 16'd2, 1'b0, 1'b0, 20, 0);
        run_op("dbz", 32'd12345, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 3, 0);
        run_op("chk_ovf", 32'h0001_0000, 16'd1, 16'd0, 16'd0, 1'b0, 1'b1, 3, 0);
        run_op("min_min", 32'h8000_0000, 16'h8000, 16'd0, 16'd0, 1'b0, 1'b1, 3, 0);
        // +32768 is not a 16-bit signed divisor; 16'h8000 is -32768, which flips the quotient sign.
        run_op("neg_min", 32'hC000_0000, 16'h8000, 16'd0, 16'd0, 1'b0, 1'b1, 20, 0);
        run_op("pos_min", 32'h4000_0000, 16'h8000, 16'h8000, 16'd0, 1'b0, 1'b0, 20, 0);
        run_op("ignored", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 20, 5);
        run_op("b2b", 32'd1000, -16'sd33, -16'sd30, 16'd10, 1'b0, 1'b0, 20, 0);
        run_abort();
        run_op("after_rst", -32'sd100, -16'sd7, 16'd14, -16'sd2, 1'b0, 1'b0, 20, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            gen_operands();
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
